psg_bus_writer: RTL and testbench
=================================

Name: psg_bus_writer

Overview:
- Host-side write sequencer for the SN76489-style PSG parallel bus; the driving end of the write interface that the chip-side logic samples.
- Accepts bytes on a valid/ready stream, buffers them in a small FIFO, and plays each byte out as a full bus cycle: data setup, CE_n/WE_n strobe, wait for the READY low-then-high handshake, hold, release.
- Sits between the CPU/register front-end and the PSG pins; a timeout guards against a dead READY line.

Parameters:
- FIFO_DEPTH, 4, byte buffer entries; power of two, ≥2.
- SETUP_CYCLES, 1, clk cycles with data and CE_n valid before WE_n falls; ≥1.
- HOLD_CYCLES, 1, clk cycles with data and CE_n held after WE_n rises; ≥1.
- READY_TIMEOUT, 64, maximum clk cycles allowed for each READY phase (fall, then rise); ≥4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- in_data  in  8  byte to write.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; equals !full.
- bus_data  out  8  PSG data bus.
- bus_ce_n  out  1  chip enable, active-low.
- bus_we_n  out  1  write strobe, active-low.
- psg_ready  in  1  chip READY; asynchronous; low = busy.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- timeout_err  out  1  one-cycle pulse when a READY phase exceeds READY_TIMEOUT.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (visible after the reset edge):
  - bus_ce_n=1, bus_we_n=1, bus_data=0.
  - FIFO empty, fifo_level=0, in_ready=1, busy=0, timeout_err=0.
  - FSM in IDLE.
  - Synchronizer flops preset to 1.
- Reset mid-cycle aborts immediately and drops all buffered bytes; no partial strobe survives reset.
- Push: in_valid & in_ready at an edge stores in_data.
- Simultaneous push and pop in one cycle is allowed, including when full: in_ready=0 when full, so a push on a full FIFO is ignored even if a pop occurs that cycle. Net level changes by push−pop.
- psg_ready passes through a 2-flop synchronizer (rdy_s). Internal edge detects use rdy_s and its previous value.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head at the edge, load bus_data, set bus_ce_n=0 → SETUP. Latency: a byte pushed at edge N into an empty FIFO shows bus_ce_n=0 after edge N+1.
  - SETUP: count SETUP_CYCLES, then bus_we_n=0, clear the timer → WAIT_LO.
  - WAIT_LO: on an rdy_s falling edge → WAIT_HI with the timer cleared. If the timer reaches READY_TIMEOUT → HOLD and pulse timeout_err.
  - WAIT_HI: on an rdy_s rising edge → HOLD, bus_we_n=1. On timeout → HOLD, bus_we_n=1, pulse timeout_err.
  - HOLD: bus_we_n=1, data and CE_n held for HOLD_CYCLES, then bus_ce_n=1 → IDLE.
- Back-to-back bytes return to IDLE for at least one cycle with bus_ce_n=1 before the next SETUP.
- A READY already low on WE_n fall still requires a fresh falling edge. A missing edge ends in timeout, and the sequencer never hangs.
- bus_data changes only on the IDLE→SETUP edge.
- Timer width is $clog2(READY_TIMEOUT+1). The timer saturates and never wraps.
- FIFO pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Full/empty is derived from the level counter.

Decomposition:
- Shared package psg_pkg holds:
  - FSM state enum: IDLE, SETUP, WAIT_LO, WAIT_HI, HOLD.
  - Byte width constant PSG_DATA_W=8.
  - Default timing constants.
- One sub-module, psg_write_fifo: synchronous FIFO with push/pop/level/full/empty, parameterised by depth and width.
- The synchronizer and FSM live in psg_bus_writer.

Test Plan:
- Reset mid-strobe: push 0x9F, assert reset while bus_we_n=0 → next cycle bus_we_n=1, bus_ce_n=1, bus_data=0x00, fifo_level=0, busy=0.
- Single write with the chip model pulling READY low 2 cycles after WE_n falls for 32 cycles → pins show:
  - bus_data=0x9F and bus_ce_n=0 after edge N+1;
  - bus_we_n low 1 cycle later, released 3 cycles after the model raises READY (2-flop sync plus edge detect);
  - bus_ce_n=1 after HOLD; no timeout_err.
- Burst: push 0x80,0x01,0x9F,0xBF,0xDF with FIFO_DEPTH=4 and no pops → in_ready=0 after 4 pushes, fifo_level=4. Drain all 5 in order, with ≥1 idle cycle of bus_ce_n=1 between cycles.
- Simultaneous push/pop: level 2, push while IDLE pops → fifo_level stays 2; data order preserved.
- READY stuck high: push 0x55 → exactly one timeout_err pulse 64 cycles after WAIT_LO entry; bus_we_n returns 1; FSM reaches IDLE; the next byte proceeds normally.
- READY stuck low after falling: → timeout_err in WAIT_HI after 64 cycles; bus released, busy=0 once the FIFO is empty.

Source files
------------

// File: rtl/psg_pkg.sv
// rtl/psg_pkg.sv - shared constants and FSM state encoding for the PSG bus writer
package psg_pkg;

  localparam int PSG_DATA_W        = 8;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_HOLD_CYCLES   = 1;
  localparam int DEF_READY_TIMEOUT = 64;

  typedef logic [2:0] psg_state_t;

  localparam psg_state_t ST_IDLE    = 3'd0;
  localparam psg_state_t ST_SETUP   = 3'd1;
  localparam psg_state_t ST_WAIT_LO = 3'd2;
  localparam psg_state_t ST_WAIT_HI = 3'd3;
  localparam psg_state_t ST_HOLD    = 3'd4;

endpackage

// File: rtl/psg_write_fifo.sv
// rtl/psg_write_fifo.sv - synchronous byte FIFO; full/empty come from the level counter
module psg_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A push on a full FIFO is dropped even when a pop happens in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/psg_bus_writer.sv
// rtl/psg_bus_writer.sv - buffered write sequencer driving the PSG CE_n/WE_n/READY bus
module psg_bus_writer
  import psg_pkg::*;
#(
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int READY_TIMEOUT = DEF_READY_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PSG_DATA_W-1:0]         in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [PSG_DATA_W-1:0]         bus_data_o,
  output logic                          bus_ce_n_o,
  output logic                          bus_we_n_o,
  input  logic                          psg_ready_i,
  output logic                          busy_o,
  output logic                          timeout_err_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int TMR_W   = $clog2(READY_TIMEOUT + 1);
  localparam int CNT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  psg_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [PSG_DATA_W-1:0] data_q, data_d;
  logic                  ce_n_q, ce_n_d;
  logic                  we_n_q, we_n_d;
  logic                  to_q, to_d;
  logic                  sync1_q, rdy_s_q, rdy_prev_q;

  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PSG_DATA_W-1:0] fifo_head;
  logic                  rdy_fall;
  logic                  rdy_rise;
  logic                  tmr_expired;
  logic [TMR_W-1:0]      tmr_next;

  psg_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PSG_DATA_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (in_valid_i),
    .push_data_i (in_data_i),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level_o)
  );

  assign rdy_fall    = rdy_prev_q & ~rdy_s_q;
  assign rdy_rise    = ~rdy_prev_q & rdy_s_q;
  // Expiry fires on the edge that would take the timer to READY_TIMEOUT.
  assign tmr_expired = (timer_q >= TMR_W'(READY_TIMEOUT - 1));
  assign tmr_next    = (timer_q == TMR_W'(READY_TIMEOUT)) ? timer_q : timer_q + TMR_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    data_d   = data_q;
    ce_n_d   = ce_n_q;
    we_n_d   = we_n_q;
    to_d     = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_head;
          ce_n_d   = 1'b0;
          cnt_d    = '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
          we_n_d  = 1'b0;
          timer_d = '0;
          state_d = ST_WAIT_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LO: begin
        if (rdy_fall) begin
          timer_d = '0;
          state_d = ST_WAIT_HI;
        end else if (tmr_expired) begin
          we_n_d  = 1'b1;
          to_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          timer_d = tmr_next;
        end
      end
      ST_WAIT_HI: begin
        if (rdy_rise || tmr_expired) begin
          we_n_d  = 1'b1;
          to_d    = ~rdy_rise;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          timer_d = tmr_next;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          ce_n_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        ce_n_d  = 1'b1;
        we_n_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      timer_q    <= '0;
      data_q     <= '0;
      ce_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      to_q       <= 1'b0;
      sync1_q    <= 1'b1;
      rdy_s_q    <= 1'b1;
      rdy_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      data_q     <= data_d;
      ce_n_q     <= ce_n_d;
      we_n_q     <= we_n_d;
      to_q       <= to_d;
      sync1_q    <= psg_ready_i;
      rdy_s_q    <= sync1_q;
      rdy_prev_q <= rdy_s_q;
    end
  end

  assign in_ready_o    = ~fifo_full;
  assign bus_data_o    = data_q;
  assign bus_ce_n_o    = ce_n_q;
  assign bus_we_n_o    = we_n_q;
  assign timeout_err_o = to_q;
  assign busy_o        = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_psg_bus_writer.sv
// tb/tb_psg_bus_writer.sv - scoreboard bench for psg_bus_writer with a simple PSG READY model
`timescale 1ns/1ps
module tb_psg_bus_writer;

  localparam int M_IDLE     = 0;
  localparam int M_NORMAL   = 1;
  localparam int M_STUCK_HI = 2;
  localparam int M_STUCK_LO = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] bus_data;
  logic       bus_ce_n;
  logic       bus_we_n;
  logic       psg_ready = 1'b1;
  logic       busy;
  logic       timeout_err;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mode = M_NORMAL;
  int push_cyc = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  psg_bus_writer #(
    .FIFO_DEPTH    (4),
    .SETUP_CYCLES  (1),
    .HOLD_CYCLES   (1),
    .READY_TIMEOUT (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data_i     (in_data),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .bus_data_o    (bus_data),
    .bus_ce_n_o    (bus_ce_n),
    .bus_we_n_o    (bus_we_n),
    .psg_ready_i   (psg_ready),
    .busy_o        (busy),
    .timeout_err_o (timeout_err),
    .fifo_level_o  (fifo_level)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // PSG model: drops READY two cycles after WE_n falls, keeps it low 32 cycles
  int mstate = 0;
  int mcnt = 0;
  int raise_cyc = -100;
  logic m_pwe = 1'b1;
  always @(negedge clk) begin
    case (mstate)
      0: if (m_pwe && !bus_we_n && !reset) begin
        if (mode == M_NORMAL) begin mcnt = 2; mstate = 1; end
        else if (mode == M_STUCK_LO) begin mcnt = 2; mstate = 3; end
      end
      1: begin mcnt--; if (mcnt == 0) begin psg_ready = 1'b0; mcnt = 32; mstate = 2; end end
      2: begin mcnt--; if (mcnt == 0) begin psg_ready = 1'b1; raise_cyc = cyc; mstate = 0; end end
      3: begin mcnt--; if (mcnt == 0) begin psg_ready = 1'b0; mstate = 4; end end
      4: if (mode != M_STUCK_LO) begin psg_ready = 1'b1; mstate = 0; end
      default: mstate = 0;
    endcase
    m_pwe = bus_we_n;
  end

  // Bus monitor: pops the scoreboard on every CE_n fall and checks strobe timing
  logic p_ce = 1'b1, p_we = 1'b1, p_rst = 1'b1, p_to = 1'b0;
  int ce_fall_cyc = 0, we_fall_cyc = 0, we_rise_cyc = 0;
  int to_cnt = 0, to_cyc = 0, n_done = 0;
  logic [7:0] cur_byte = 8'h00;
  always @(negedge clk) begin
    if (!reset && !p_rst) begin
      if (p_ce && !bus_ce_n) begin
        ce_fall_cyc = cyc;
        cur_byte = bus_data;
        check_eq("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) check_eq("sb_data", bus_data, sb.pop_front());
      end
      if (p_we && !bus_we_n) begin
        we_fall_cyc = cyc;
        check_eq("setup_lat", cyc - ce_fall_cyc, 1);
      end
      if (!p_we && bus_we_n) begin
        we_rise_cyc = cyc;
        if (mode == M_NORMAL) check_eq("ready_rel_lat", cyc - raise_cyc, 3);
      end
      if (!p_ce && bus_ce_n) begin
        check_eq("hold_lat", cyc - we_rise_cyc, 1);
        check_eq("data_held", bus_data, cur_byte);
        n_done++;
      end
      if (timeout_err) begin
        check_eq("to_single", p_to, 0);
        to_cnt++;
        to_cyc = cyc;
      end
    end
    p_ce = bus_ce_n;
    p_we = bus_we_n;
    p_to = timeout_err;
    p_rst = reset;
  end

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check_eq("push_ready", in_ready, 1);
    in_data = b;
    in_valid = 1'b1;
    sb.push_back(b);
    push_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin @(negedge clk); n++; end
    check_eq("idle_reached", busy, 0);
  endtask

  task automatic check_reset_pins(input string tag);
    check_eq({tag, "_ce_n"}, bus_ce_n, 1);
    check_eq({tag, "_we_n"}, bus_we_n, 1);
    check_eq({tag, "_data"}, bus_data, 0);
    check_eq({tag, "_level"}, fifo_level, 0);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_timeout"}, timeout_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, d0, n;
    repeat (3) @(negedge clk);
    check_reset_pins("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single write with a well-behaved chip
    mode = M_NORMAL;
    t0 = to_cnt;
    push_byte(8'h9F);
    wait_idle(300);
    check_eq("first_ce_lat", ce_fall_cyc - push_cyc, 2);
    check_eq("single_no_to", to_cnt - t0, 0);

    // burst fills the FIFO while the first byte is on the bus
    d0 = n_done;
    push_byte(8'h80);
    push_byte(8'h01);
    push_byte(8'h9F);
    push_byte(8'hBF);
    push_byte(8'hDF);
    check_eq("burst_level", fifo_level, 4);
    check_eq("burst_full", in_ready, 0);
    in_data = 8'h11;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("full_push_ignored", fifo_level, 4);
    wait_idle(1000);
    check_eq("burst_done", n_done - d0, 5);
    check_eq("burst_no_to", to_cnt - t0, 0);

    // push lands on the same edge the IDLE state pops
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte(8'h56);
    n = 0;
    while (bus_ce_n && n < 50) begin @(negedge clk); n++; end
    while (!bus_ce_n && n < 200) begin @(negedge clk); n++; end
    check_eq("pre_pp_level", fifo_level, 2);
    in_data = 8'h78;
    in_valid = 1'b1;
    sb.push_back(8'h78);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("pp_level", fifo_level, 2);
    check_eq("pp_popped", bus_ce_n, 0);
    wait_idle(1000);

    // READY never falls
    mode = M_STUCK_HI;
    t0 = to_cnt;
    push_byte(8'h55);
    wait_idle(300);
    check_eq("stuck_hi_to_cnt", to_cnt - t0, 1);
    check_eq("stuck_hi_to_lat", to_cyc - we_fall_cyc, 64);
    check_eq("stuck_hi_we_n", bus_we_n, 1);
    mode = M_NORMAL;
    t0 = to_cnt;
    push_byte(8'h66);
    wait_idle(300);
    check_eq("after_to_normal", to_cnt - t0, 0);

    // READY falls but never rises again
    mode = M_STUCK_LO;
    t0 = to_cnt;
    push_byte(8'h77);
    wait_idle(400);
    check_eq("stuck_lo_to_cnt", to_cnt - t0, 1);
    check_eq("stuck_lo_to_lat", to_cyc - we_fall_cyc, 69);
    check_eq("stuck_lo_ce_n", bus_ce_n, 1);
    check_eq("stuck_lo_we_n", bus_we_n, 1);
    mode = M_IDLE;
    repeat (5) @(negedge clk);

    // reset while WE_n is low, with a second byte still buffered
    mode = M_STUCK_HI;
    push_byte(8'h9F);
    push_byte(8'h44);
    n = 0;
    while (bus_we_n && n < 50) begin @(negedge clk); n++; end
    check_eq("we_low_before_rst", bus_we_n, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_pins("midrst");
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    mode = M_NORMAL;
    repeat (5) @(negedge clk);
    check_eq("dropped_bytes", busy, 0);
    check_eq("dropped_ce_n", bus_ce_n, 1);

    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
